// File: rtl/srff_pkg.sv
// Shared mode encoding and single-bit next-state rule for the SR flip-flop bank.
package srff_pkg;

  localparam logic [1:0] SRFF_SET_DOM = 2'd0;
  localparam logic [1:0] SRFF_RST_DOM = 2'd1;
  localparam logic [1:0] SRFF_TOGGLE  = 2'd2;
  localparam logic [1:0] SRFF_HOLD    = 2'd3;

  function automatic logic srff_next(input logic [1:0] mode, input logic s, input logic r,
                                     input logic q);
    logic nxt;
    nxt = q;
    unique case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b00: nxt = q;
      default: begin
        // Both strobes active: the bank's conflict policy decides.
        unique case (mode)
          SRFF_SET_DOM: nxt = 1'b1;
          SRFF_RST_DOM: nxt = 1'b0;
          SRFF_TOGGLE:  nxt = ~q;
          default:      nxt = q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/srff_cell.sv
// One SR flip-flop channel: state, change-detect pulse and sticky conflict flag.
module srff_cell
  import srff_pkg::*;
#(
  parameter logic [1:0] MODE      = SRFF_SET_DOM,
  parameter logic       RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic conflict_clr,
  output logic q,
  output logic changed,
  output logic conflict
);

  logic q_d, q_q;
  logic changed_d, changed_q;
  logic conflict_d, conflict_q;

  always_comb begin
    q_d        = en ? srff_next(MODE, s, r, q_q) : q_q;
    changed_d  = q_d != q_q;
    // A conflict arriving on the clearing edge takes priority over the clear.
    conflict_d = (en & s & r) | (conflict_q & ~conflict_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= RESET_VAL;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/srff_bank.sv
// Bank of WIDTH independent SR flip-flops with shared enable, conflict clear and reset.
module srff_bank
  import srff_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          MODE      = 32'(SRFF_SET_DOM),
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict
);

  localparam logic [1:0] ModeSel = MODE[1:0];

  if (MODE > 32'd3) begin : g_bad_mode
    $fatal(1, "srff_bank: illegal MODE %0d", MODE);
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "srff_bank: WIDTH %0d out of range 1..64", WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell #(
      .MODE      (ModeSel),
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s[i]),
      .r            (r[i]),
      .conflict_clr (conflict_clr),
      .q            (q[i]),
      .changed      (changed[i]),
      .conflict     (conflict[i])
    );
  end

  // Derived from the registered state, so still free of input-to-output paths.
  assign qbar = ~q;

endmodule

// File: tb/tb_srff_bank.sv
// Drives all four conflict modes in parallel and checks them against a vector-level model.
module tb_srff_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s = '0;
  logic [7:0] r = '0;
  logic       conflict_clr = 1'b0;

  logic [7:0] q_a[4];
  logic [7:0] qbar_a[4];
  logic [7:0] changed_a[4];
  logic [7:0] conflict_a[4];

  // Model state per mode: 0 set-dominant, 1 reset-dominant, 2 toggle, 3 hold.
  logic [7:0] mq[4];
  logic [7:0] mch[4];
  logic [7:0] mcf[4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    srff_bank #(
      .WIDTH     (8),
      .MODE      (m),
      .RESET_VAL (RV)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s),
      .r            (r),
      .conflict_clr (conflict_clr),
      .q            (q_a[m]),
      .qbar         (qbar_a[m]),
      .changed      (changed_a[m]),
      .conflict     (conflict_a[m])
    );
  end

  function automatic logic [7:0] model_next(int mode, logic [7:0] qv, logic [7:0] sv,
                                            logic [7:0] rv);
    logic [7:0] both_val;
    case (mode)
      0:       both_val = 8'hFF;
      1:       both_val = 8'h00;
      2:       both_val = ~qv;
      default: both_val = qv;
    endcase
    return (qv & ~(sv | rv)) | (sv & ~rv) | (sv & rv & both_val);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 4; m++) begin
      check($sformatf("q_m%0d", m), q_a[m], mq[m]);
      check($sformatf("qbar_m%0d", m), qbar_a[m], ~mq[m]);
      check($sformatf("changed_m%0d", m), changed_a[m], mch[m]);
      check($sformatf("conflict_m%0d", m), conflict_a[m], mcf[m]);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then compare.
  task automatic step(input logic rs, input logic e, input logic [7:0] sv, input logic [7:0] rv,
                      input logic clr);
    logic [7:0] nq;
    rst = rs;
    en = e;
    s = sv;
    r = rv;
    conflict_clr = clr;
    @(posedge clk);
    for (int m = 0; m < 4; m++) begin
      if (rs) begin
        mq[m] = RV;
        mch[m] = '0;
        mcf[m] = '0;
      end else begin
        nq = e ? model_next(m, mq[m], sv, rv) : mq[m];
        mch[m] = nq ^ mq[m];
        mq[m] = nq;
        mcf[m] = (clr ? 8'h00 : mcf[m]) | (e ? (sv & rv) : 8'h00);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      mq[m] = 'x;
      mch[m] = 'x;
      mcf[m] = 'x;
    end

    // Reset held two cycles, then an idle enabled cycle.
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
    check("reset_q", q_a[0], 8'hA5);
    check("reset_qbar", qbar_a[0], 8'h5A);
    check("reset_changed", changed_a[0], 8'h00);
    check("reset_conflict", conflict_a[0], 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check("first_idle_changed", changed_a[0], 8'h00);

    // Basic set/reset from zero.
    step(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("set_q", q_a[0], 8'h0F);
    check("set_changed", changed_a[0], 8'h0F);
    step(1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("reset_again_changed", changed_a[0], 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h03, 1'b0);
    check("rst_bits_q", q_a[0], 8'h0C);
    check("rst_bits_changed", changed_a[0], 8'h03);

    // Mode resolution from q=F0 with s=r=FF.
    step(1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    check("setdom_q", q_a[0], 8'hFF);
    check("rstdom_q", q_a[1], 8'h00);
    check("toggle_q", q_a[2], 8'h0F);
    check("hold_q", q_a[3], 8'hF0);
    check("hold_changed", changed_a[3], 8'h00);
    for (int m = 0; m < 4; m++) check($sformatf("conflict_ff_m%0d", m), conflict_a[m], 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    check("toggle_q2", q_a[2], 8'hF0);
    check("toggle_changed2", changed_a[2], 8'hFF);

    // Enable gating.
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    check("en0_changed", changed_a[1], 8'h00);
    check("en0_q", q_a[1], 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    check("en1_q", q_a[1], 8'hFF);

    // Conflict clear racing a new conflict.
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    check("conflict_01", conflict_a[0], 8'h01);
    step(1'b0, 1'b1, 8'h02, 8'h02, 1'b1);
    check("conflict_race", conflict_a[0], 8'h02);

    // Reset in the middle of toggling bit 0.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b0);
    check("midrst_q", q_a[2], 8'hA5);
    check("midrst_conflict", conflict_a[2], 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
           8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
